// File: rtl/pos_word_updater_if.sv
// Write-only RAM port between the position updater and the external arbiter.
interface pos_word_updater_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [15:0]           ram_data;
    logic                  ram_we;
    logic                  wr_grant;

    modport master (
        output ram_addr,
        output ram_data,
        output ram_we,
        input  wr_grant
    );

    modport slave (
        input  ram_addr,
        input  ram_data,
        input  ram_we,
        output wr_grant
    );
endinterface

// File: rtl/pos_word_updater.sv
// Per-frame game-state engine: advances the man's jump physics and the cactus
// scroll, then writes cactus X and man Y into shared RAM through an arbiter.
module pos_word_updater #(
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] POS_BASE       = 'h8000,
    parameter logic [9:0]            GROUND_Y       = 10'd100,
    parameter logic [7:0]            JUMP_V         = 8'd12,
    parameter logic [7:0]            GRAVITY        = 8'd1,
    parameter logic [9:0]            CACTUS_START_X = 10'd608,
    parameter logic [9:0]            CACTUS_SPEED   = 10'd4
) (
    input  logic                sys_clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                jump_btn,
    pos_word_updater_if.master  bus,
    output logic [9:0]          man_y,
    output logic [9:0]          cactus_x,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, UPDATE, WR_CX, WR_MY} state_t;

    state_t             state;
    logic               pending;
    logic               jump_req;
    logic signed [7:0]  vel;
    logic               sync1, sync2, btn_prev;
    logic               btn_rise;

    logic signed [7:0]  v;
    logic signed [10:0] y_sum;
    logic [9:0]         y_nxt;
    logic signed [7:0]  vel_nxt;
    logic [9:0]         cx_nxt;

    assign btn_rise = sync2 & ~btn_prev;

    // Bring the asynchronous button into sys_clk and keep a delayed copy for edge detect
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            sync1    <= jump_btn;
            sync2    <= sync1;
            btn_prev <= sync2;
        end
    end

    // Next-frame physics: jump launch, clamped Y integration, cactus scroll with wrap
    always_comb begin
        v       = vel;
        y_nxt   = man_y;
        vel_nxt = vel;
        if (jump_req && man_y == GROUND_Y && vel == 8'sd0)
            v = 8'sd0 - $signed(JUMP_V);
        y_sum = $signed({1'b0, man_y}) + $signed({{3{v[7]}}, v});
        if (y_sum < 11'sd0) begin
            y_nxt   = 10'd0;
            vel_nxt = 8'sd0;
        end else if (y_sum >= $signed({1'b0, GROUND_Y})) begin
            y_nxt   = GROUND_Y;
            vel_nxt = 8'sd0;
        end else begin
            y_nxt   = y_sum[9:0];
            vel_nxt = v + $signed(GRAVITY);
        end
        cx_nxt = (cactus_x < CACTUS_SPEED) ? CACTUS_START_X : cactus_x - CACTUS_SPEED;
    end

    // Control FSM with registered write port; ticks seen while busy collapse into one pending update
    always_ff @(posedge sys_clk) begin
        if (!reset) begin
            state        <= IDLE;
            pending      <= 1'b0;
            jump_req     <= 1'b0;
            vel          <= 8'sd0;
            man_y        <= GROUND_Y;
            cactus_x     <= CACTUS_START_X;
            busy         <= 1'b0;
            bus.ram_we   <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_data <= '0;
        end else begin
            if (btn_rise)
                jump_req <= 1'b1;
            if (frame_tick && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_tick || pending) begin
                        state   <= UPDATE;
                        pending <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                UPDATE: begin
                    man_y        <= y_nxt;
                    vel          <= vel_nxt;
                    cactus_x     <= cx_nxt;
                    // cleared even if unused so a stale press never fires later
                    jump_req     <= 1'b0;
                    bus.ram_we   <= 1'b1;
                    bus.ram_addr <= POS_BASE;
                    bus.ram_data <= {6'b0, cx_nxt};
                    state        <= WR_CX;
                end
                WR_CX: begin
                    if (bus.wr_grant) begin
                        bus.ram_addr <= POS_BASE + 1'b1;
                        bus.ram_data <= {6'b0, man_y};
                        state        <= WR_MY;
                    end
                end
                WR_MY: begin
                    if (bus.wr_grant) begin
                        bus.ram_we <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
